lifo_pop_stream: RTL and testbench

LIFO_POP_STREAM -- requirements
Module: lifo_pop_stream

---
 rtl/lifo_pop_stream.sv | 129 ++++++++++++
 tb/tb_lifo_pop_stream.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_pop_stream.sv
// lifo_pop_stream
// Drains a requested number of words from an upstream LIFO and presents
// them as a valid/ready stream, in pop order (last pushed first).
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready request handshake, accepted only while idle
//   cmd_len             words to pop for this burst (0..16)
//   lifo_empty/lifo_pop LIFO empty flag and pop strobe
//   lifo_data           registered LIFO output, valid the cycle after a pop
//   m_valid/m_ready     output stream handshake
//   m_data/m_last       output word and last-of-burst marker
//   done/done_cnt/done_short  one-cycle completion pulse with delivered count
//                       and a flag for a burst cut short by an empty LIFO
module lifo_pop_stream #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             lifo_empty,
    output logic             lifo_pop,
    input  logic [WIDTH-1:0] lifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             done,
    output logic [LEN_W-1:0] done_cnt,
    output logic             done_short
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_POP   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LEN_W-1:0] ONE = 1;

    logic [1:0]       state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] delivered;
    logic             inflight;
    logic [1:0]       occ;
    logic [WIDTH-1:0] skid0;
    logic [WIDTH-1:0] skid1;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             fire;
    logic             room;

    assign m_valid = !rst && (occ != 2'd0);
    assign fire    = m_valid && m_ready;

    // A pop is allowed only if the word it fetches is guaranteed a slot in
    // the skid buffer, counting the word already in flight and crediting a
    // word leaving this very cycle; this keeps one word per cycle streaming.
    assign room     = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, fire});
    assign lifo_pop = !rst && (state == S_POP) && !lifo_empty
                      && (issued < len_q) && room;

    assign cmd_ready  = !rst && (state == S_IDLE);
    assign m_data     = rst ? '0 : (rd_ptr ? skid1 : skid0);
    // A short burst never reaches index len-1, so m_last cannot fire on it.
    assign m_last     = m_valid && (delivered == len_q - ONE);
    assign done       = !rst && (state == S_DONE);
    assign done_cnt   = done ? delivered : '0;
    assign done_short = done && (delivered < len_q);

    // Burst sequencing, skid buffer and counters. The word popped in one
    // cycle appears on lifo_data in the next, so the in-flight flag is
    // simply the previous cycle's pop and doubles as the capture enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
            occ       <= 2'd0;
            skid0     <= '0;
            skid1     <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
        end else begin
            inflight <= lifo_pop;
            if (inflight) begin
                if (wr_ptr) skid1 <= lifo_data;
                else        skid0 <= lifo_data;
                wr_ptr <= ~wr_ptr;
            end
            if (fire) begin
                rd_ptr    <= ~rd_ptr;
                delivered <= delivered + ONE;
            end
            occ <= occ + {1'b0, inflight} - {1'b0, fire};
            if (lifo_pop) issued <= issued + ONE;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        len_q     <= cmd_len;
                        issued    <= '0;
                        delivered <= '0;
                        state     <= (cmd_len == '0) ? S_DONE : S_POP;
                    end
                end
                S_POP: begin
                    // Leave once every pop is issued, or when the LIFO ran
                    // dry and no fetched word is still on its way.
                    if ((issued == len_q) || (lifo_empty && !inflight))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if ((occ == 2'd0) && !inflight)
                        state <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lifo_pop_stream.sv
// tb_lifo_pop_stream
// Self-checking bench for lifo_pop_stream. An upstream LIFO is modelled as
// a stack; on each accepted request the expected output stream is taken
// directly from the top of that stack, and a negedge process compares every
// delivered word, marker and completion pulse against it.
module tb_lifo_pop_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_len;
    logic        lifo_empty;
    logic        lifo_pop;
    logic [15:0] lifo_data = '0;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        done;
    logic [4:0]  done_cnt;
    logic        done_short;

    int errors = 0;
    int checks = 0;

    lifo_pop_stream #(.WIDTH(16), .LEN_W(5)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .lifo_empty(lifo_empty), .lifo_pop(lifo_pop), .lifo_data(lifo_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .done(done), .done_cnt(done_cnt), .done_short(done_short)
    );

    always #5 clk = ~clk;

    // Upstream LIFO: a stack whose top is returned one cycle after a pop.
    logic [15:0] stack [0:31];
    int          sp = 0;
    logic [15:0] load_vals [0:31];
    int          load_n = 0;
    logic        load_req = 1'b0;

    assign lifo_empty = (sp == 0);

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < load_n; i++) stack[i] <= load_vals[i];
            sp <= load_n;
        end else if (lifo_pop && sp != 0) begin
            lifo_data <= stack[sp-1];
            sp <= sp - 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state, owned by the compare process.
    logic [15:0] exp_q [$];
    int          exp_len = 0;
    int          exp_idx = 0;
    int          exp_cnt = 0;
    bit          exp_short = 0;
    int          cyc = 0;
    int          done_count = 0;
    int          pops_total = 0;
    int          last_done_cnt = 0;
    int          last_done_short = 0;
    int          accept_cyc = 0;
    int          done_cyc = 0;
    int          first_pop_cyc = 0;
    int          last_pop_cyc = 0;
    int          first_fire_cyc = 0;
    int          last_fire_cyc = 0;
    int          burst_pops = 0;
    int          burst_beats = 0;
    int          burst_lasts = 0;
    logic [15:0] first_word = '0;
    bit          prev_hold = 0;
    logic [15:0] prev_data = '0;

    // Compare process: checks outputs away from the active edge on every
    // cycle they carry meaning.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            prev_hold = 0;
        end else begin
            if (lifo_pop) begin
                checkOutput("pop_while_empty", {31'd0, lifo_empty}, 32'd0);
                pops_total++;
                if (burst_pops == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                burst_pops++;
            end
            if (prev_hold) begin
                checkOutput("hold_valid", {31'd0, m_valid}, 32'd1);
                checkOutput("hold_data", {16'd0, m_data}, {16'd0, prev_data});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_word", 32'd1, 32'd0);
                end else begin
                    checkOutput("m_data", {16'd0, m_data}, {16'd0, exp_q[0]});
                    checkOutput("m_last", {31'd0, m_last},
                                {31'd0, exp_idx == exp_len - 1});
                    void'(exp_q.pop_front());
                end
                if (burst_beats == 0) begin
                    first_word = m_data;
                    first_fire_cyc = cyc;
                end
                last_fire_cyc = cyc;
                if (m_last) burst_lasts++;
                burst_beats++;
                exp_idx++;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            if (done) begin
                checkOutput("done_cnt", {27'd0, done_cnt}, exp_cnt);
                checkOutput("done_short", {31'd0, done_short}, {31'd0, exp_short});
                last_done_cnt = done_cnt;
                last_done_short = done_short;
                done_cyc = cyc;
                done_count++;
            end
            if (cmd_valid && cmd_ready) begin
                exp_len = cmd_len;
                exp_cnt = (exp_len < sp) ? exp_len : sp;
                exp_short = (exp_cnt < exp_len);
                exp_idx = 0;
                exp_q.delete();
                for (int k = 0; k < exp_cnt; k++) exp_q.push_back(stack[sp-1-k]);
                accept_cyc = cyc;
                burst_pops = 0;
                burst_beats = 0;
                burst_lasts = 0;
            end
        end
    end

    int stall_pops;

    task automatic loadStack(input int n, input logic [15:0] base);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) load_vals[i] = base + 16'(i);
        load_n = n;
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    // mode 0: m_ready held high; 1: held low for 5 cycles then high;
    // 2: m_ready random each cycle.
    task automatic applyStimulus(input int len, input int mode);
        int dc;
        bit finished;
        dc = done_count;
        finished = 0;
        stall_pops = 0;
        cmd_valid = 1'b1;
        cmd_len = 5'(len);
        m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done_count != dc) begin
                finished = 1;
                break;
            end
            if (mode == 1 && i == 4) begin
                stall_pops = burst_pops;
                m_ready = 1'b1;
            end else if (mode == 2) begin
                m_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        if (!finished) checkOutput("done_timeout", 32'd0, 32'd1);
        m_ready = 1'b0;
    endtask

    task automatic checkBurst(input int cnt, input int shrt, input int pops);
        checkOutput("all_delivered", exp_q.size(), 32'd0);
        checkOutput("burst_done_cnt", last_done_cnt, cnt);
        checkOutput("burst_done_short", last_done_short, shrt);
        checkOutput("burst_pops", burst_pops, pops);
        checkOutput("burst_beats", burst_beats, cnt);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("rst_lifo_pop", {31'd0, lifo_pop}, 32'd0);
        checkOutput("rst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("rst_m_last", {31'd0, m_last}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_done_cnt", {27'd0, done_cnt}, 32'd0);
        checkOutput("rst_done_short", {31'd0, done_short}, 32'd0);
        checkOutput("rst_m_data", {16'd0, m_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // A,B,C with C on top: C,B,A back to back, m_last on A.
        loadStack(3, 16'hA000);
        applyStimulus(3, 0);
        checkBurst(3, 0, 3);
        checkOutput("first_word_C", {16'd0, first_word}, 32'hA002);
        checkOutput("pop_span", last_pop_cyc - first_pop_cyc, 32'd2);
        checkOutput("beat_span", last_fire_cyc - first_fire_cyc, 32'd2);
        checkOutput("one_last", burst_lasts, 32'd1);

        // Only 2 words for a request of 5: short burst, no m_last.
        loadStack(2, 16'hB000);
        applyStimulus(5, 0);
        checkBurst(2, 1, 2);
        checkOutput("short_no_last", burst_lasts, 32'd0);
        checkOutput("short_first_word", {16'd0, first_word}, 32'hB001);

        // Downstream stalled for 5 cycles: at most 2 pops, then all 4 words.
        loadStack(6, 16'hC000);
        applyStimulus(4, 1);
        checkOutput("stall_pops_le2", {31'd0, stall_pops <= 2}, 32'd1);
        checkBurst(4, 0, 4);
        checkOutput("stall_first_word", {16'd0, first_word}, 32'hC005);

        // Zero-length request: no pop, done the cycle after accept.
        loadStack(3, 16'hD000);
        applyStimulus(0, 0);
        checkBurst(0, 0, 0);
        checkOutput("zero_done_latency", done_cyc - accept_cyc, 32'd1);

        // Reset in the middle of a stalled burst holding two buffered words.
        loadStack(6, 16'hE000);
        cmd_valid = 1'b1;
        cmd_len = 5'd4;
        m_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pre_rst_valid", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        checkOutput("mid_rst_lifo_pop", {31'd0, lifo_pop}, 32'd0);
        checkOutput("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("after_rst_m_valid", {31'd0, m_valid}, 32'd0);
        loadStack(3, 16'hF000);
        applyStimulus(3, 0);
        checkBurst(3, 0, 3);
        checkOutput("after_rst_first_word", {16'd0, first_word}, 32'hF002);

        // Maximum burst with random back-pressure.
        loadStack(20, 16'h1000);
        applyStimulus(16, 2);
        checkBurst(16, 0, 16);
        checkOutput("max_first_word", {16'd0, first_word}, 32'h1013);
        checkOutput("max_one_last", burst_lasts, 32'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
